// File: rtl/ama_riscv_pipeline_ctrl_pkg.sv
// Shared types for the pipeline controller: FSM state encoding, stage indices
// and the per-stage enable/kill bundle.
package ama_riscv_pipeline_ctrl_pkg;

    // Controller FSM state, exported on pipe_state
    typedef enum logic [1:0] {
        PS_RUN   = 2'd0,
        PS_HAZ   = 2'd1,
        PS_DCS   = 2'd2,
        PS_FLUSH = 2'd3
    } pipe_state_t;

    // Stage indices into the enable/kill vectors
    localparam int unsigned STG_FET = 0;
    localparam int unsigned STG_DEC = 1;
    localparam int unsigned STG_EXE = 2;
    localparam int unsigned STG_MEM = 3;
    localparam int unsigned STG_WBK = 4;

    // Per-stage controls; FET has no kill, a bubble enters at the FET->DEC register
    typedef struct packed {
        logic [STG_WBK:STG_FET] en;
        logic [STG_WBK:STG_DEC] kill;
    } pipe_ctrl_t;

    // Free-running pipe: everything advances, nothing is squashed
    localparam pipe_ctrl_t CTRL_RUN = '{en: '1, kill: '0};

    // Held in reset: nothing advances, every stage is squashed
    localparam pipe_ctrl_t CTRL_RESET = '{en: '0, kill: '1};

endpackage

// File: rtl/ama_riscv_pipeline_ctrl_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Sticks at all-ones instead of wrapping.
module ama_riscv_pipeline_ctrl_sat_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;

    // Count up on inc, hold at max, clear on request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/ama_riscv_pipeline_ctrl.sv
// 5-stage pipeline controller (FET/DEC/EXE/MEM/WBK). Produces the stage
// register enables and bubble kills from the EXE hazard, cache stalls and the
// EXE redirect; tracks the pipe FSM and a sticky stall watchdog.
// Optional build macro PIPE_CTRL_PERF_EN adds hazard/dc-stall/flush perf
// counters; without it the cnt_* outputs are constant zero.
module ama_riscv_pipeline_ctrl
    import ama_riscv_pipeline_ctrl_pkg::*;
#(
    parameter int unsigned STALL_TMO = 1024,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard_to_exe,
    input  logic             dc_stalled,
    input  logic             ic_stalled,
    input  logic             redirect_exe,
    output logic             en_fet,
    output logic             en_dec,
    output logic             en_exe,
    output logic             en_mem,
    output logic             en_wbk,
    output logic             kill_dec,
    output logic             kill_exe,
    output logic             kill_mem,
    output logic             kill_wbk,
    output pipe_state_t      pipe_state,
    output logic             stall_tmo,
    output logic [CNT_W-1:0] cnt_haz,
    output logic [CNT_W-1:0] cnt_dcs,
    output logic [CNT_W-1:0] cnt_flush
);

    localparam int unsigned     WD_W   = $clog2(STALL_TMO + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(STALL_TMO);

    pipe_state_t     state_q;
    pipe_ctrl_t      ctrl;
    logic            ev_dcs;
    logic            ev_haz;
    logic            ev_redir;
    logic            ev_ic;
    logic            wd_busy;
    logic [WD_W-1:0] wd_cnt;
    logic            stall_tmo_q;

    // Resolve the per-cycle event by priority: dcs > hazard > redirect > ic
    assign ev_dcs   = dc_stalled;
    assign ev_haz   = hazard_to_exe & ~dc_stalled;
    assign ev_redir = redirect_exe & ~dc_stalled & ~hazard_to_exe;
    assign ev_ic    = ic_stalled & ~dc_stalled & ~hazard_to_exe & ~redirect_exe;

    // Decode stage enables and kills for this cycle from the winning event
    always_comb begin
        ctrl = CTRL_RUN;
        if (ev_dcs) begin
            // Whole pipe frozen; WBK must not retire the held instruction twice
            ctrl.en            = '0;
            ctrl.kill[STG_WBK] = 1'b1;
        end else if (ev_haz) begin
            // Front end and EXE hold, a bubble slides into MEM
            ctrl.en[STG_FET]   = 1'b0;
            ctrl.en[STG_DEC]   = 1'b0;
            ctrl.en[STG_EXE]   = 1'b0;
            ctrl.kill[STG_MEM] = 1'b1;
        end else if (ev_redir) begin
            // Squash the two wrong-path instructions behind the branch
            ctrl.kill[STG_DEC] = 1'b1;
            ctrl.kill[STG_EXE] = 1'b1;
            // Target fetch missed in I$: retry it next cycle
            ctrl.en[STG_FET]   = ~ic_stalled;
        end else if (ev_ic) begin
            ctrl.en[STG_FET]   = 1'b0;
            ctrl.kill[STG_DEC] = 1'b1;
        end else if (state_q == PS_FLUSH) begin
            // Sync IMEM: target instruction not yet out of the fetch stage
            ctrl.kill[STG_DEC] = 1'b1;
        end
        if (rst) begin
            ctrl = CTRL_RESET;
        end
    end

    assign en_fet   = ctrl.en[STG_FET];
    assign en_dec   = ctrl.en[STG_DEC];
    assign en_exe   = ctrl.en[STG_EXE];
    assign en_mem   = ctrl.en[STG_MEM];
    assign en_wbk   = ctrl.en[STG_WBK];
    assign kill_dec = ctrl.kill[STG_DEC];
    assign kill_exe = ctrl.kill[STG_EXE];
    assign kill_mem = ctrl.kill[STG_MEM];
    assign kill_wbk = ctrl.kill[STG_WBK];

    // Pipe FSM; an I$ stall leaves a pending FLUSH in place, otherwise returns to RUN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PS_RUN;
        end else if (ev_dcs) begin
            state_q <= PS_DCS;
        end else if (ev_haz) begin
            state_q <= PS_HAZ;
        end else if (ev_redir) begin
            state_q <= PS_FLUSH;
        end else if (ev_ic && (state_q == PS_FLUSH)) begin
            state_q <= PS_FLUSH;
        end else begin
            state_q <= PS_RUN;
        end
    end

    assign pipe_state = state_q;

    // Watchdog: any non-plain-RUN cycle counts, a plain RUN cycle restarts it
    assign wd_busy = (state_q != PS_RUN) | hazard_to_exe | dc_stalled | ic_stalled;

    ama_riscv_pipeline_ctrl_sat_cnt #(
        .W (WD_W)
    ) u_wd_cnt (
        .clk (clk),
        .rst (rst),
        .clr (~wd_busy),
        .inc (wd_busy && (wd_cnt != WD_MAX)),
        .cnt (wd_cnt)
    );

    // Sticky timeout flag, set on the edge where the count reaches STALL_TMO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_tmo_q <= 1'b0;
        end else if (wd_busy && (wd_cnt == (WD_MAX - WD_W'(1)))) begin
            stall_tmo_q <= 1'b1;
        end
    end

    assign stall_tmo = stall_tmo_q;

`ifdef PIPE_CTRL_PERF_EN
    ama_riscv_pipeline_ctrl_sat_cnt #(
        .W (CNT_W)
    ) u_cnt_haz (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (ev_haz),
        .cnt (cnt_haz)
    );

    ama_riscv_pipeline_ctrl_sat_cnt #(
        .W (CNT_W)
    ) u_cnt_dcs (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (ev_dcs),
        .cnt (cnt_dcs)
    );

    ama_riscv_pipeline_ctrl_sat_cnt #(
        .W (CNT_W)
    ) u_cnt_flush (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (ev_redir),
        .cnt (cnt_flush)
    );
`else
    assign cnt_haz   = '0;
    assign cnt_dcs   = '0;
    assign cnt_flush = '0;
`endif

endmodule
